// File: rtl/sdram_device_emu.sv
// SDR SDRAM device emulator: decodes the SDRAM command pins, tracks open rows and tRCD per bank,
// stores data in an internal array and returns read data after the programmed CAS latency.
module sdram_device_emu #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned COL_W  = 8,
    parameter int unsigned BANK_W = 2,
    parameter int unsigned MEM_AW = 12,
    parameter int unsigned T_RCD  = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_sdram_cke,
    input  logic                  i_sdram_cs_n,
    input  logic                  i_sdram_ras_n,
    input  logic                  i_sdram_cas_n,
    input  logic                  i_sdram_wen_n,
    input  logic [ADDR_W-1:0]     i_sdram_addr,
    input  logic [BANK_W-1:0]     i_sdram_ba,
    input  logic [DATA_W/8-1:0]   i_sdram_dqm,
    inout  wire  [DATA_W-1:0]     io_sdram_dq,
    output logic                  o_mode_set,
    output logic [2**BANK_W-1:0]  o_bank_open,
    output logic [15:0]           o_refresh_cnt,
    output logic [3:0]            o_err
);

    localparam int unsigned NumBanks = 2**BANK_W;
    localparam int unsigned NumBytes = DATA_W / 8;
    localparam int unsigned RcdW     = $clog2(T_RCD + 1);

    typedef enum logic {StUninit, StReady} state_e;

    state_e                state_q;
    logic                  cl3_q;
    logic [NumBanks-1:0]   bank_open_q;
    logic [ADDR_W-1:0]     row_q [NumBanks];
    logic [RcdW-1:0]       rcd_q [NumBanks];
    logic [15:0]           refresh_q;
    logic [3:0]            err_q;

    // Two-stage read pipe feeding the dq output register; CL3 enters one stage earlier.
    logic                  pipe_v_q [2];
    logic [DATA_W-1:0]     pipe_d_q [2];
    logic [NumBytes-1:0]   pipe_m_q [2];
    logic                  out_v_q;
    logic [DATA_W-1:0]     out_d_q;
    logic [NumBytes-1:0]   out_m_q;

    logic [DATA_W-1:0]     mem [2**MEM_AW];

    logic                  cmd_en;
    logic [2:0]            cmd;
    logic                  is_act, is_rd, is_wr, is_pre, is_ref, is_lmr;
    logic                  bank_hit, any_open, rd_pending, mode_ok;
    logic                  do_rd, do_wr;
    logic [MEM_AW-1:0]     mem_idx;
    logic [DATA_W-1:0]     rd_word;

    always_comb begin
        cmd_en     = i_sdram_cke && !i_sdram_cs_n;
        cmd        = {i_sdram_ras_n, i_sdram_cas_n, i_sdram_wen_n};
        is_act     = cmd_en && (cmd == 3'b011);
        is_rd      = cmd_en && (cmd == 3'b101);
        is_wr      = cmd_en && (cmd == 3'b100);
        is_pre     = cmd_en && (cmd == 3'b010);
        is_ref     = cmd_en && (cmd == 3'b001);
        is_lmr     = cmd_en && (cmd == 3'b000);
        bank_hit   = bank_open_q[i_sdram_ba];
        any_open   = |bank_open_q;
        rd_pending = pipe_v_q[0] || pipe_v_q[1] || out_v_q;
        mode_ok    = (i_sdram_addr[6:5] == 2'b01) && (i_sdram_addr[2:0] == 3'b000);
        do_rd      = is_rd && (state_q == StReady) && bank_hit;
        do_wr      = is_wr && (state_q == StReady) && bank_hit;
        mem_idx    = MEM_AW'({i_sdram_ba, row_q[i_sdram_ba], i_sdram_addr[COL_W-1:0]});
        rd_word    = mem[mem_idx];
    end

    // Backing store is deliberately not reset so contents survive a reset.
    always_ff @(posedge i_clk) begin
        if (do_wr) begin
            for (int k = 0; k < NumBytes; k++) begin
                if (!i_sdram_dqm[k]) mem[mem_idx][8*k +: 8] <= io_sdram_dq[8*k +: 8];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= StUninit;
            cl3_q       <= 1'b0;
            bank_open_q <= '0;
            refresh_q   <= '0;
            err_q       <= '0;
            out_v_q     <= 1'b0;
            out_d_q     <= '0;
            out_m_q     <= '0;
            for (int b = 0; b < NumBanks; b++) begin
                row_q[b] <= '0;
                rcd_q[b] <= '0;
            end
            for (int s = 0; s < 2; s++) begin
                pipe_v_q[s] <= 1'b0;
                pipe_d_q[s] <= '0;
                pipe_m_q[s] <= '0;
            end
        end else begin
            if (i_sdram_cke) begin
                for (int b = 0; b < NumBanks; b++) begin
                    if (rcd_q[b] != '0) rcd_q[b] <= rcd_q[b] - 1'b1;
                end
                out_v_q     <= pipe_v_q[0];
                out_d_q     <= pipe_d_q[0];
                out_m_q     <= pipe_m_q[0];
                pipe_v_q[0] <= pipe_v_q[1];
                pipe_d_q[0] <= pipe_d_q[1];
                pipe_m_q[0] <= pipe_m_q[1];
                pipe_v_q[1] <= 1'b0;
                if (do_rd) begin
                    if (cl3_q) begin
                        pipe_v_q[1] <= 1'b1;
                        pipe_d_q[1] <= rd_word;
                        pipe_m_q[1] <= i_sdram_dqm;
                    end else begin
                        pipe_v_q[0] <= 1'b1;
                        pipe_d_q[0] <= rd_word;
                        pipe_m_q[0] <= i_sdram_dqm;
                    end
                end
            end

            if (is_act) begin
                if (state_q == StUninit) begin
                    err_q[2] <= 1'b1;
                end else begin
                    if (bank_hit) err_q[0] <= 1'b1;
                    bank_open_q[i_sdram_ba] <= 1'b1;
                    row_q[i_sdram_ba]       <= i_sdram_addr;
                    rcd_q[i_sdram_ba]       <= RcdW'(T_RCD - 1);
                end
            end

            if (is_rd || is_wr) begin
                if (state_q == StUninit) begin
                    err_q[2] <= 1'b1;
                end else if (!bank_hit) begin
                    err_q[0] <= 1'b1;
                end else begin
                    if (rcd_q[i_sdram_ba] != '0) err_q[1] <= 1'b1;
                    if (is_wr && rd_pending) err_q[0] <= 1'b1;
                end
            end

            if (is_pre) begin
                if (i_sdram_addr[10]) bank_open_q <= '0;
                else                  bank_open_q[i_sdram_ba] <= 1'b0;
            end

            if (is_ref) begin
                refresh_q <= refresh_q + 16'd1;
                if (any_open) err_q[0] <= 1'b1;
            end

            if (is_lmr) begin
                if (any_open) begin
                    err_q[0] <= 1'b1;
                end else if (!mode_ok) begin
                    err_q[3] <= 1'b1;
                end else begin
                    cl3_q   <= i_sdram_addr[4];
                    state_q <= StReady;
                end
            end
        end
    end

    assign o_mode_set    = (state_q == StReady);
    assign o_bank_open   = bank_open_q;
    assign o_refresh_cnt = refresh_q;
    assign o_err         = err_q;

    for (genvar k = 0; k < NumBytes; k++) begin : g_dq
        assign io_sdram_dq[8*k +: 8] = (out_v_q && !out_m_q[k]) ? out_d_q[8*k +: 8] : {8{1'bz}};
    end

endmodule

// File: tb/tb_sdram_device_emu.sv
// Directed bench for sdram_device_emu: expected read beats go to a queue that a negedge monitor
// checks against dq; register-style outputs are checked inline.
module tb_sdram_device_emu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cke = 1'b1;
    logic        cs_n = 1'b1;
    logic        ras_n = 1'b1;
    logic        cas_n = 1'b1;
    logic        wen_n = 1'b1;
    logic [10:0] addr = '0;
    logic [1:0]  ba = '0;
    logic [3:0]  dqm = '0;
    logic        tb_oe = 1'b0;
    logic [31:0] tb_dq = '0;
    wire  [31:0] dq;
    logic        mode_set;
    logic [3:0]  bank_open;
    logic [15:0] refresh_cnt;
    logic [3:0]  err;

    assign dq = tb_oe ? tb_dq : 'z;

    sdram_device_emu dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_sdram_cke   (cke),
        .i_sdram_cs_n  (cs_n),
        .i_sdram_ras_n (ras_n),
        .i_sdram_cas_n (cas_n),
        .i_sdram_wen_n (wen_n),
        .i_sdram_addr  (addr),
        .i_sdram_ba    (ba),
        .i_sdram_dqm   (dqm),
        .io_sdram_dq   (dq),
        .o_mode_set    (mode_set),
        .o_bank_open   (bank_open),
        .o_refresh_cnt (refresh_cnt),
        .o_err         (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int          edge_n;
        logic [31:0] data;
        logic [3:0]  zmask;
        string       name;
    } beat_t;

    beat_t exp_q[$];
    int    tests = 0;
    int    fails = 0;
    int    cl = 2;

    // A released bus reads as z in 4-state tools and as 0 in 2-state ones.
    function automatic bit byte_is_z(input logic [7:0] b);
        return (b === 8'hzz) || (b === 8'h00);
    endfunction

    always @(negedge clk) begin : monitor
        beat_t b;
        bit    ok;
        if (!rst && !tb_oe) begin
            if (exp_q.size() > 0 && exp_q[0].edge_n <= cyc) begin
                b = exp_q.pop_front();
                tests++;
                fails++;
                $display("FAIL %s: beat never seen by edge %0d, expected %h", b.name, b.edge_n,
                         b.data);
            end
            ok = 1'b1;
            if (exp_q.size() > 0 && exp_q[0].edge_n == cyc + 1) begin
                b = exp_q.pop_front();
                for (int k = 0; k < 4; k++) begin
                    if (b.zmask[k]) ok &= byte_is_z(dq[8*k +: 8]);
                    else            ok &= (dq[8*k +: 8] === b.data[8*k +: 8]);
                end
                tests++;
                if (!ok) begin
                    fails++;
                    $display("FAIL %s: dq got %h, expected %h (z bytes %b) at edge %0d", b.name, dq,
                             b.data, b.zmask, b.edge_n);
                end
            end else begin
                for (int k = 0; k < 4; k++) ok &= byte_is_z(dq[8*k +: 8]);
                tests++;
                if (!ok) begin
                    fails++;
                    $display("FAIL idle_z: dq got %h, expected Z before edge %0d", dq, cyc + 1);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, expv);
        end
    endtask

    task automatic issue(input logic [2:0] c, input logic [10:0] a, input logic [1:0] b,
                         input logic [3:0] m, input logic [31:0] d, output int n);
        {ras_n, cas_n, wen_n} = c;
        cs_n  = 1'b0;
        addr  = a;
        ba    = b;
        dqm   = m;
        tb_dq = d;
        tb_oe = (c == 3'b100);
        @(posedge clk);
        #1;
        n = cyc;
        cs_n = 1'b1;
        {ras_n, cas_n, wen_n} = 3'b111;
        dqm   = '0;
        tb_oe = 1'b0;
    endtask

    task automatic nop(input int k);
        int n;
        for (int i = 0; i < k; i++) issue(3'b111, '0, '0, '0, '0, n);
    endtask

    task automatic cmd(input logic [2:0] c, input logic [10:0] a, input logic [1:0] b);
        int n;
        issue(c, a, b, '0, '0, n);
    endtask

    task automatic wr(input logic [1:0] b, input logic [10:0] col, input logic [31:0] d,
                      input logic [3:0] m);
        int n;
        issue(3'b100, col, b, m, d, n);
    endtask

    task automatic rd(input string nm, input logic [1:0] b, input logic [10:0] col,
                      input logic [3:0] m, input logic [31:0] expd);
        int n;
        issue(3'b101, col, b, m, '0, n);
        exp_q.push_back('{n + cl, expd, m, nm});
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cl  = 2;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_err", 32'(err), 32'h0);
        check("reset_bank_open", 32'(bank_open), 32'h0);
        check("reset_mode_set", 32'(mode_set), 32'h0);
        check("reset_refresh", 32'(refresh_cnt), 32'h0);

        // 1: access before LOAD MODE
        cmd(3'b011, 11'h000, 2'd0);
        check("preinit_err", 32'(err), 32'h4);
        check("preinit_bank_open", 32'(bank_open), 32'h0);

        // 2: CL2 write then read
        pulse_reset();
        cmd(3'b000, 11'h020, 2'd0);
        check("mode_set_cl2", 32'(mode_set), 32'h1);
        cmd(3'b011, 11'h000, 2'd0);
        nop(2);
        wr(2'd0, 11'd0, 32'h11223344, 4'b0000);
        rd("rd_cl2", 2'd0, 11'd0, 4'b0000, 32'h11223344);
        nop(3);
        check("cl2_err", 32'(err), 32'h0);

        // 3: byte-masked write, then masked read
        wr(2'd0, 11'd0, 32'hAABBCCDD, 4'b0101);
        rd("rd_masked_wr", 2'd0, 11'd0, 4'b0000, 32'hAA22CC44);
        nop(3);
        rd("rd_masked_rd", 2'd0, 11'd0, 4'b0011, 32'hAA22CC44);
        nop(3);
        check("dqm_err", 32'(err), 32'h0);

        // 4: closed bank, then tRCD violation
        cmd(3'b101, 11'h000, 2'd1);
        nop(3);
        check("closed_rd_err", 32'(err), 32'h1);
        check("closed_rd_banks", 32'(bank_open), 32'h1);
        cmd(3'b011, 11'd5, 2'd1);
        nop(2);
        wr(2'd1, 11'd3, 32'h55667788, 4'b0000);
        cmd(3'b010, 11'h000, 2'd1);
        check("pre_one_banks", 32'(bank_open), 32'h1);
        cmd(3'b011, 11'd5, 2'd1);
        rd("rd_trcd", 2'd1, 11'd3, 4'b0000, 32'h55667788);
        nop(3);
        check("trcd_err", 32'(err), 32'h3);

        // 5: CL3 back-to-back reads, then rejected mode
        cmd(3'b010, 11'h400, 2'd0);
        check("pre_all_banks", 32'(bank_open), 32'h0);
        cmd(3'b000, 11'h030, 2'd0);
        cl = 3;
        cmd(3'b011, 11'h000, 2'd0);
        nop(2);
        wr(2'd0, 11'd1, 32'h01020304, 4'b0000);
        wr(2'd0, 11'd2, 32'h05060708, 4'b0000);
        rd("rd_cl3_a", 2'd0, 11'd1, 4'b0000, 32'h01020304);
        rd("rd_cl3_b", 2'd0, 11'd2, 4'b0000, 32'h05060708);
        nop(4);
        check("cl3_err", 32'(err), 32'h3);
        cmd(3'b010, 11'h400, 2'd0);
        cmd(3'b000, 11'h010, 2'd0);
        check("bad_mode_err", 32'(err), 32'hB);
        check("bad_mode_set", 32'(mode_set), 32'h1);
        cmd(3'b011, 11'h000, 2'd0);
        nop(2);
        rd("rd_cl3_kept", 2'd0, 11'd2, 4'b0000, 32'h05060708);
        nop(4);

        // 6: refresh counting, refresh with open bank, reset during a beat
        pulse_reset();
        check("reset2_err", 32'(err), 32'h0);
        for (int i = 0; i < 5; i++) cmd(3'b001, 11'h000, 2'd0);
        check("refresh5_cnt", 32'(refresh_cnt), 32'd5);
        check("refresh5_err", 32'(err), 32'h0);
        cmd(3'b000, 11'h020, 2'd0);
        cmd(3'b011, 11'd1, 2'd2);
        cmd(3'b001, 11'h000, 2'd0);
        check("refresh_open_err", 32'(err), 32'h1);
        check("refresh_open_cnt", 32'(refresh_cnt), 32'd6);
        nop(1);
        wr(2'd2, 11'd0, 32'hCAFEF00D, 4'b0000);
        rd("rd_before_rst", 2'd2, 11'd0, 4'b0000, 32'hCAFEF00D);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_dq_z", 32'(byte_is_z(dq[7:0]) && byte_is_z(dq[15:8]) &&
                                byte_is_z(dq[23:16]) && byte_is_z(dq[31:24])), 32'h1);
        check("rst_err", 32'(err), 32'h0);
        check("rst_banks", 32'(bank_open), 32'h0);
        check("rst_mode", 32'(mode_set), 32'h0);
        check("rst_refresh", 32'(refresh_cnt), 32'h0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        nop(3);
        check("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
